// File: rtl/cve2_fetch_fifo_param_if.sv
// Fetch-side and decode-side signals of the prefetch FIFO, bundled with
// modports for the FIFO itself (slave) and its driver/consumer (master).
interface cve2_fetch_fifo_param_if #(
  parameter int unsigned NUM_REQS = 2
);
  localparam int unsigned LVL_W = $clog2(NUM_REQS + 2);

  logic                clear_i;
  logic                in_valid_i;
  logic [31:0]         in_addr_i;
  logic [31:0]         in_rdata_i;
  logic                in_err_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         out_addr_o;
  logic [31:0]         out_rdata_o;
  logic                out_err_o;
  logic                out_err_plus2_o;
  logic                out_compressed_o;
  logic [NUM_REQS-1:0] busy_o;
  logic [LVL_W-1:0]    level_o;
  logic                afull_o;
  logic                overflow_o;

  modport slave (
    input  clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
    output out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o,
           out_compressed_o, busy_o, level_o, afull_o, overflow_o
  );

  modport master (
    output clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
    input  out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o,
           out_compressed_o, busy_o, level_o, afull_o, overflow_o
  );
endinterface

// File: rtl/cve2_fetch_fifo_param.sv
// Instruction prefetch FIFO: in-order shift buffer of fetched words that
// realigns compressed/unaligned instructions and tracks the current PC.
module cve2_fetch_fifo_param #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned AFULL_LVL  = NUM_REQS,
  parameter bit          ERR_ON_OVF = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cve2_fetch_fifo_param_if.slave bus
);
  localparam int unsigned DEPTH = NUM_REQS + 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [31:0]      rdata_q [DEPTH];
  logic [31:0]      rdata_d [DEPTH];
  logic [31:0]      pc_q, pc_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      head_rdata, next_rdata, out_rdata;
  logic             head_err, next_err, head_c, aligned;
  logic             out_valid, out_err, out_err_plus2, out_compressed;
  logic             accept, pop, pop_from_in, shift, push;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH:0]   below_valid;
  logic [LVL_W-1:0] level;

  // Head and next words fall back to the incoming bus word when not yet stored.
  always_comb begin
    head_rdata     = valid_q[0] ? rdata_q[0] : bus.in_rdata_i;
    head_err       = valid_q[0] ? err_q[0]   : bus.in_err_i;
    next_rdata     = valid_q[1] ? rdata_q[1] : bus.in_rdata_i;
    next_err       = valid_q[1] ? err_q[1]   : bus.in_err_i;
    aligned        = ~pc_q[1];
    head_c         = (head_rdata[17:16] != 2'b11);
    out_rdata      = head_rdata;
    out_err        = head_err;
    out_err_plus2  = 1'b0;
    out_valid      = valid_q[0] | bus.in_valid_i;
    out_compressed = (head_rdata[1:0] != 2'b11) & ~head_err;
    if (!aligned) begin
      out_rdata      = {next_rdata[15:0], head_rdata[31:16]};
      out_compressed = head_c & ~head_err;
      if (!head_c) begin
        out_valid     = valid_q[1] | (valid_q[0] & bus.in_valid_i);
        out_err       = head_err | next_err;
        out_err_plus2 = ~head_err & next_err;
      end
    end
  end

  // An aligned compressed accept leaves the upper half in the head word.
  always_comb begin
    accept      = out_valid & bus.out_ready_i;
    pop         = accept & ~(aligned & out_compressed);
    pop_from_in = pop & ~valid_q[0];
    shift       = pop & valid_q[0] & ~bus.clear_i;
    push        = bus.in_valid_i & ~pop_from_in & ~bus.clear_i;
    valid_s     = shift ? (valid_q >> 1) : valid_q;
    below_valid = {valid_s, 1'b1};

    valid_d    = valid_s;
    rdata_d    = rdata_q;
    err_d      = err_q;
    pc_d       = pc_q;
    overflow_d = overflow_q;

    for (int i = 0; i < DEPTH - 1; i++) begin
      if (shift && valid_q[i+1]) begin
        rdata_d[i] = rdata_q[i+1];
        err_d[i]   = err_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !valid_s[i] && below_valid[i]) begin
        valid_d[i] = 1'b1;
        rdata_d[i] = bus.in_rdata_i;
        err_d[i]   = bus.in_err_i;
      end
    end

    if (push && (&valid_s) && ERR_ON_OVF) overflow_d = 1'b1;
    if (accept) pc_d = pc_q + (out_compressed ? 32'd2 : 32'd4);

    if (bus.clear_i) begin
      valid_d    = '0;
      pc_d       = bus.in_addr_i & ~32'd1;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      err_q      <= '0;
      pc_q       <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      err_q      <= err_d;
      pc_q       <= pc_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < DEPTH; i++) level = level + LVL_W'(valid_q[i]);
  end

  assign bus.out_valid_o      = out_valid;
  assign bus.out_addr_o       = pc_q;
  assign bus.out_rdata_o      = out_rdata;
  assign bus.out_err_o        = out_err;
  assign bus.out_err_plus2_o  = out_err_plus2;
  assign bus.out_compressed_o = out_compressed;
  assign bus.busy_o           = valid_q[DEPTH-1:1];
  assign bus.level_o          = level;
  assign bus.afull_o          = (level >= LVL_W'(AFULL_LVL));
  assign bus.overflow_o       = overflow_q;

endmodule

// File: tb/tb_cve2_fetch_fifo_param.sv
// Bench for the prefetch FIFO: directed vector table, hand-written realignment
// sequences and a randomized run against a queue-based reference model.
module tb_cve2_fetch_fifo_param;
  localparam int unsigned NUM_REQS  = 2;
  localparam int unsigned DEPTH     = NUM_REQS + 1;
  localparam int unsigned AFULL_LVL = NUM_REQS;
  localparam int unsigned LVL_W     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cve2_fetch_fifo_param_if #(.NUM_REQS(NUM_REQS)) bus ();

  cve2_fetch_fifo_param #(
    .NUM_REQS   (NUM_REQS),
    .AFULL_LVL  (AFULL_LVL),
    .ERR_ON_OVF (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } word_t;

  // Reference model: queue of stored words, current PC and sticky overflow.
  word_t       mq[$];
  logic [31:0] mpc  = '0;
  logic        movf = 1'b0;

  logic                exp_valid, exp_err, exp_plus2, exp_comp, exp_full, exp_afull, exp_ovf;
  logic [31:0]         exp_addr, exp_rdata;
  logic [LVL_W-1:0]    exp_level;
  logic [NUM_REQS-1:0] exp_busy;

  typedef struct {
    logic                rst, clear, in_valid;
    logic [31:0]         addr, rdata;
    logic                err, ready, chk_data, exp_valid;
    logic [31:0]         exp_addr, exp_rdata;
    logic [LVL_W-1:0]    exp_level;
    logic [NUM_REQS-1:0] exp_busy;
    logic                exp_afull, exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic applyStimulus(input logic r, input logic c, input logic iv,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic e, input logic rdy);
    rst            = r;
    bus.clear_i    = c;
    bus.in_valid_i = iv;
    bus.in_addr_i  = a;
    bus.in_rdata_i = d;
    bus.in_err_i   = e;
    bus.out_ready_i = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // The instruction stream is the stored words followed by any incoming word.
  task automatic modelOutputs();
    word_t s[$];
    logic  hc;
    s = mq;
    if (bus.in_valid_i) s.push_back('{data: bus.in_rdata_i, err: bus.in_err_i});
    exp_addr  = mpc;
    exp_level = LVL_W'(mq.size());
    exp_afull = (mq.size() >= int'(AFULL_LVL));
    exp_ovf   = movf;
    for (int i = 1; i < int'(DEPTH); i++) exp_busy[i-1] = (mq.size() > i);
    exp_valid = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_plus2 = 1'b0;
    exp_comp  = 1'b0;
    exp_full  = 1'b0;
    if (!mpc[1]) begin
      if (s.size() >= 1) begin
        exp_valid = 1'b1;
        exp_full  = 1'b1;
        exp_rdata = s[0].data;
        exp_err   = s[0].err;
        exp_comp  = (s[0].data[1:0] != 2'b11) && !s[0].err;
      end
    end else if (s.size() >= 1) begin
      hc = (s[0].data[17:16] != 2'b11);
      if (hc) begin
        exp_valid = 1'b1;
        exp_rdata = {16'h0, s[0].data[31:16]};
        exp_err   = s[0].err;
        exp_comp  = !s[0].err;
      end else if (s.size() >= 2) begin
        exp_valid = 1'b1;
        exp_full  = 1'b1;
        exp_rdata = {s[1].data[15:0], s[0].data[31:16]};
        exp_err   = s[0].err | s[1].err;
        exp_plus2 = !s[0].err && s[1].err;
      end
    end
  endtask

  task automatic modelStep();
    int consume;
    if (rst) begin
      mq.delete();
      mpc  = '0;
      movf = 1'b0;
    end else if (bus.clear_i) begin
      mq.delete();
      mpc  = bus.in_addr_i & ~32'd1;
      movf = 1'b0;
    end else begin
      modelOutputs();
      consume = 0;
      if (exp_valid && bus.out_ready_i) begin
        if (mpc[1] || !exp_comp) consume = 1;
        mpc = mpc + (exp_comp ? 32'd2 : 32'd4);
      end
      if (bus.in_valid_i) begin
        if (mq.size() == int'(DEPTH) && consume == 0) movf = 1'b1;
        else mq.push_back('{data: bus.in_rdata_i, err: bus.in_err_i});
      end
      if (consume == 1) void'(mq.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        2'd0, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,    32'hAAAA0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'hAAAA0003, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,    32'hBBBB0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'hAAAA0003, 2'd1, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,    32'hCCCC0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'hAAAA0003, 2'd2, 2'b01, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'hAAAA0003, 2'd3, 2'b11, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,    32'hEEEE0003, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000, 32'hAAAA0003, 2'd3, 2'b11, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,    32'hDDDD0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1004, 32'hBBBB0003, 2'd3, 2'b11, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h1004, 32'hBBBB0003, 2'd3, 2'b11, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h2000, 32'h99990003, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1004, 32'hBBBB0003, 2'd3, 2'b11, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0,        2'd0, 2'b00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h11110003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h11110003, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h22220003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h11110003, 2'd1, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h3000, 32'h33330003, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'h11110003, 2'd2, 2'b01, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        2'd0, 2'b00, 1'b0, 1'b0};

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    tick();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].clear, vecs[i].in_valid, vecs[i].addr,
                    vecs[i].rdata, vecs[i].err, vecs[i].ready);
      #1;
      checkOutput($sformatf("vec%0d.valid", i), 32'(bus.out_valid_o), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d.addr", i), bus.out_addr_o, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d.level", i), 32'(bus.level_o), 32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d.busy", i), 32'(bus.busy_o), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d.afull", i), 32'(bus.afull_o), 32'(vecs[i].exp_afull));
      checkOutput($sformatf("vec%0d.ovf", i), 32'(bus.overflow_o), 32'(vecs[i].exp_ovf));
      if (vecs[i].chk_data) checkOutput($sformatf("vec%0d.rdata", i), bus.out_rdata_o, vecs[i].exp_rdata);
      tick();
    end

    // Compressed at 0x100 keeps the word; the 0x0000 upper half is itself compressed.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00004501, 1'b0, 1'b1);
    #1;
    checkOutput("seqA.valid0", 32'(bus.out_valid_o), 32'd1);
    checkOutput("seqA.addr0", bus.out_addr_o, 32'h100);
    checkOutput("seqA.rdata0", bus.out_rdata_o, 32'h00004501);
    checkOutput("seqA.comp0", 32'(bus.out_compressed_o), 32'd1);
    checkOutput("seqA.plus2_0", 32'(bus.out_err_plus2_o), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00000013, 1'b0, 1'b1);
    #1;
    checkOutput("seqA.addr1", bus.out_addr_o, 32'h102);
    checkOutput("seqA.rdata1", bus.out_rdata_o, 32'h00130000);
    checkOutput("seqA.comp1", 32'(bus.out_compressed_o), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("seqA.addr2", bus.out_addr_o, 32'h104);
    checkOutput("seqA.rdata2", bus.out_rdata_o, 32'h00000013);
    checkOutput("seqA.comp2", 32'(bus.out_compressed_o), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("seqA.addr3", bus.out_addr_o, 32'h108);
    checkOutput("seqA.level3", 32'(bus.level_o), 32'd0);

    // Unaligned 32-bit instruction waits for its second half.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h203, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00930000, 1'b0, 1'b0);
    #1;
    checkOutput("seqB.addr0", bus.out_addr_o, 32'h202);
    checkOutput("seqB.valid0", 32'(bus.out_valid_o), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00000513, 1'b0, 1'b1);
    #1;
    checkOutput("seqB.valid1", 32'(bus.out_valid_o), 32'd1);
    checkOutput("seqB.rdata1", bus.out_rdata_o, 32'h05130093);
    checkOutput("seqB.comp1", 32'(bus.out_compressed_o), 32'd0);
    checkOutput("seqB.err1", 32'(bus.out_err_o), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("seqB.addr2", bus.out_addr_o, 32'h206);
    checkOutput("seqB.level2", 32'(bus.level_o), 32'd1);

    // Error only in the second word of an unaligned instruction.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h302, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00930000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00000513, 1'b1, 1'b0);
    #1;
    checkOutput("seqC.valid0", 32'(bus.out_valid_o), 32'd1);
    checkOutput("seqC.err0", 32'(bus.out_err_o), 32'd1);
    checkOutput("seqC.plus2_0", 32'(bus.out_err_plus2_o), 32'd1);
    checkOutput("seqC.comp0", 32'(bus.out_compressed_o), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("seqC.err1", 32'(bus.out_err_o), 32'd1);
    checkOutput("seqC.plus2_1", 32'(bus.out_err_plus2_o), 32'd1);

    // Aligned errored word: never compressed, never a +2 error.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h00000001, 1'b1, 1'b0);
    #1;
    checkOutput("seqD.err", 32'(bus.out_err_o), 32'd1);
    checkOutput("seqD.plus2", 32'(bus.out_err_plus2_o), 32'd0);
    checkOutput("seqD.comp", 32'(bus.out_compressed_o), 32'd0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      d = $urandom();
      if ($urandom_range(1, 0) == 1) d[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) d[17:16] = 2'b11;
      applyStimulus(($urandom_range(149, 0) == 0), ($urandom_range(24, 0) == 0),
                    ($urandom_range(9, 0) < 6), $urandom(), d,
                    ($urandom_range(15, 0) == 0), ($urandom_range(1, 0) == 1));
      #1;
      modelOutputs();
      checkOutput("rnd.valid", 32'(bus.out_valid_o), 32'(exp_valid));
      checkOutput("rnd.addr", bus.out_addr_o, exp_addr);
      checkOutput("rnd.level", 32'(bus.level_o), 32'(exp_level));
      checkOutput("rnd.busy", 32'(bus.busy_o), 32'(exp_busy));
      checkOutput("rnd.afull", 32'(bus.afull_o), 32'(exp_afull));
      checkOutput("rnd.ovf", 32'(bus.overflow_o), 32'(exp_ovf));
      if (exp_valid) begin
        checkOutput("rnd.rdata_lo", 32'(bus.out_rdata_o[15:0]), 32'(exp_rdata[15:0]));
        if (exp_full) checkOutput("rnd.rdata", bus.out_rdata_o, exp_rdata);
        checkOutput("rnd.err", 32'(bus.out_err_o), 32'(exp_err));
        checkOutput("rnd.plus2", 32'(bus.out_err_plus2_o), 32'(exp_plus2));
        checkOutput("rnd.comp", 32'(bus.out_compressed_o), 32'(exp_comp));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
